// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Request/response bundle between the SEQ sequencer and the memory stage.
//   master : sequencer side, drives start/icode/valE/valA/valP and observes
//            busy/done/valM/dmem_error/stat.
//   slave  : memory stage side, the mirror image.
interface mem_access_stage_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;

  modport master (
    output start, icode, valE, valA, valP,
    input  busy, done, valM, dmem_error, stat
  );

  modport slave (
    input  start, icode, valE, valA, valP,
    output busy, done, valM, dmem_error, stat
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory stage of the SEQ Y86-64 datapath. Selects the data address from
// valE/valA by icode, range-checks it, then performs an 8-byte little-endian
// read or write against an internal byte-addressed data memory. A
// start/busy/done handshake lets the sequencer stall until valM is valid.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset (memory contents are kept)
//   bus    : mem_access_stage_if.slave
//            start/icode/valE/valA/valP in, busy/done/valM/dmem_error/stat out
// Parameters:
//   DEPTH  : data memory size in bytes (valid addresses 0..DEPTH-1)
// Configuration macro:
//   MEM_FAST_EN : when defined, all 8 bytes are moved in a single ACCESS cycle;
//                 otherwise one byte per cycle over 8 cycles.
module mem_access_stage #(
  parameter int DEPTH = 1024
) (
  input logic              clk,
  input logic              reset,
  mem_access_stage_if.slave bus
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] LAST_BASE = 64'(DEPTH - 8);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_next;

  logic [7:0] mem [DEPTH];

  logic        req_read, req_write, req_addr_vala, req_mem, req_inrange;
  logic [63:0] req_addr, req_data;
  logic [2:0]  req_stat;

  logic          op_write;
  logic [AW-1:0] base;
  logic [63:0]   wdata;
  logic [63:0]   valm_q;
  logic [2:0]    stat_q;
  logic          err_q;
  logic          busy_c, done_c;

`ifndef MEM_FAST_EN
  logic [2:0]    cnt;
  logic [AW-1:0] byte_addr;

  assign byte_addr = base + AW'(cnt);
`endif

  // Request decode: which operand is the address, what gets written, and
  // the status the request will report. Out-of-range memory ops become ADR.
  always_comb begin
    req_read      = 1'b0;
    req_write     = 1'b0;
    req_addr_vala = 1'b0;
    req_stat      = STAT_AOK;
    case (bus.icode)
      4'h0:                      req_stat = STAT_HLT;
      4'h5:                      req_read = 1'b1;
      4'h9, 4'hB: begin
        req_read      = 1'b1;
        req_addr_vala = 1'b1;
      end
      4'h4, 4'hA, 4'h8:          req_write = 1'b1;
      4'hC, 4'hD, 4'hE, 4'hF:    req_stat = STAT_INS;
      default: ;
    endcase
    req_addr    = req_addr_vala ? bus.valA : bus.valE;
    req_data    = (bus.icode == 4'h8) ? bus.valP : bus.valA;
    req_mem     = req_read | req_write;
    req_inrange = (req_addr <= LAST_BASE);
    if (req_mem && !req_inrange) begin
      req_stat = STAT_ADR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. Only in-range memory ops visit ACCESS;
  // everything else goes straight to DONE so done follows one cycle later.
  always_comb begin
    state_next = state;
    busy_c     = (state != IDLE);
    done_c     = (state == DONE);
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (req_mem && req_inrange) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
`ifdef MEM_FAST_EN
        state_next = DONE;
`else
        if (cnt == 3'd7) begin
          state_next = DONE;
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch and read-data assembly. valM/stat/dmem_error are only
  // touched when a start is accepted or a read byte arrives, so they hold
  // their values between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_write <= 1'b0;
      base     <= '0;
      wdata    <= '0;
      valm_q   <= '0;
      stat_q   <= STAT_AOK;
      err_q    <= 1'b0;
`ifndef MEM_FAST_EN
      cnt      <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_write <= req_write;
            base     <= req_addr[AW-1:0];
            wdata    <= req_data;
            valm_q   <= '0;
            stat_q   <= req_stat;
            err_q    <= req_mem && !req_inrange;
`ifndef MEM_FAST_EN
            cnt      <= 3'd0;
`endif
          end
        end
        ACCESS: begin
`ifdef MEM_FAST_EN
          if (!op_write) begin
            for (int i = 0; i < 8; i++) begin
              valm_q[8*i +: 8] <= mem[base + AW'(i)];
            end
          end
`else
          if (!op_write) begin
            valm_q[{cnt, 3'b000} +: 8] <= mem[byte_addr];
          end
          cnt <= cnt + 3'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Data memory writes. No reset on the array; a reset arriving mid-write
  // blocks the byte of that edge while earlier bytes remain stored.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && op_write) begin
`ifdef MEM_FAST_EN
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= wdata[8*i +: 8];
      end
`else
      mem[byte_addr] <= wdata[{cnt, 3'b000} +: 8];
`endif
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.valM       = valm_q;
  assign bus.stat       = stat_q;
  assign bus.dmem_error = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Self-checking bench for mem_access_stage: directed vector table, hand
// sequences for reset/handshake corner cases, and randomized requests
// compared against a byte-array reference model of the data memory.
module tb_mem_access_stage;

  localparam int DEPTH = 1024;
`ifdef MEM_FAST_EN
  localparam int MEMLAT   = 2;
  localparam int PULSE_AT = 1;
  localparam int RST_AT   = 1;
  localparam logic [63:0] RST_READ = 64'h0;
`else
  localparam int MEMLAT   = 9;
  localparam int PULSE_AT = 2;
  localparam int RST_AT   = 4;
  localparam logic [63:0] RST_READ = 64'h0000000000AAAAAA;
`endif

  logic clk = 1'b0;
  logic reset;

  mem_access_stage_if bus();

  mem_access_stage #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl [DEPTH];

  typedef struct {
    string       name;
    logic [3:0]  ic;
    logic [63:0] e;
    logic [63:0] a;
    logic [63:0] p;
    logic [63:0] m;
    logic [2:0]  s;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: decides the operation from the icode rules, range-checks
  // the address, and moves 8 bytes little-endian through the byte array.
  task automatic modelOp(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, output logic [63:0] m, output logic [2:0] s,
                         output logic err, output int lat);
    logic [63:0] addr;
    logic [63:0] data;
    bit rd;
    bit wr;
    m = 64'h0; s = 3'd1; err = 1'b0; lat = 1;
    rd = 1'b0; wr = 1'b0; addr = e; data = a;
    case (ic)
      4'h0: s = 3'd2;
      4'h5: rd = 1'b1;
      4'h9, 4'hB: begin rd = 1'b1; addr = a; end
      4'h4, 4'hA: wr = 1'b1;
      4'h8: begin wr = 1'b1; data = p; end
      4'hC, 4'hD, 4'hE, 4'hF: s = 3'd4;
      default: ;
    endcase
    if (rd || wr) begin
      if (addr > 64'(DEPTH - 8)) begin
        s = 3'd3;
        err = 1'b1;
      end else begin
        lat = MEMLAT;
        for (int i = 0; i < 8; i++) begin
          if (rd) m = m | (64'(mdl[int'(addr) + i]) << (8 * i));
          else    mdl[int'(addr) + i] = 8'(data >> (8 * i));
        end
      end
    end
  endtask

  // Issue one request at a negedge and wait (bounded) for done. Returns the
  // outputs seen in the done cycle, the start-to-done latency in cycles, and
  // the done level one cycle later.
  task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                               input logic [63:0] p, output logic [63:0] m, output logic [2:0] s,
                               output logic err, output int lat, output logic doneAfter);
    bus.start = 1'b1;
    bus.icode = ic;
    bus.valE  = e;
    bus.valA  = a;
    bus.valP  = p;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    m   = bus.valM;
    s   = bus.stat;
    err = bus.dmem_error;
    @(negedge clk);
    doneAfter = bus.done;
  endtask

  task automatic runCheck(input string name, input logic [3:0] ic, input logic [63:0] e,
                          input logic [63:0] a, input logic [63:0] p);
    logic [63:0] m, xm;
    logic [2:0]  s, xs;
    logic        err, xerr, da;
    int          lat, xlat;
    applyStimulus(ic, e, a, p, m, s, err, lat, da);
    modelOp(ic, e, a, p, xm, xs, xerr, xlat);
    checkOutput({name, " valM"}, m, xm);
    checkOutput({name, " stat"}, 64'(s), 64'(xs));
    checkOutput({name, " dmem_error"}, 64'(err), 64'(xerr));
    checkOutput({name, " latency"}, 64'(lat), 64'(xlat));
    checkOutput({name, " done width"}, 64'(da), 64'h0);
  endtask

  initial begin
    logic [63:0] m, xm;
    logic [2:0]  s, xs;
    logic        err, xerr, da;
    int          lat, xlat, dc;
    logic [63:0] doneValM;
    logic [2:0]  doneStat;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.icode = 4'h0;
    bus.valE = 64'h0;
    bus.valA = 64'h0;
    bus.valP = 64'h0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;

    // Reset values after two cycles of reset.
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(bus.busy), 64'h0);
    checkOutput("reset done", 64'(bus.done), 64'h0);
    checkOutput("reset valM", bus.valM, 64'h0);
    checkOutput("reset stat", 64'(bus.stat), 64'h1);
    checkOutput("reset dmem_error", 64'(bus.dmem_error), 64'h0);
    reset = 1'b0;

    // Give the data memory known (zero) contents.
    for (int i = 0; i < DEPTH / 8; i++) begin
      applyStimulus(4'h4, 64'(i * 8), 64'h0, 64'h0, m, s, err, lat, da);
    end

    // Directed vectors from the specification examples.
    vecs.push_back('{"wr10",    4'h4, 64'h10,  64'h1122334455667788, 64'h0,  64'h0,                 3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"rd10",    4'h5, 64'h10,  64'h0,                64'h0,  64'h1122334455667788,  3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"rd13",    4'h5, 64'h13,  64'h0,                64'h0,  64'h0000001122334455,  3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"call",    4'h8, 64'h3F8, 64'h5555,             64'h2A, 64'h0,                 3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"ret",     4'h9, 64'h10,  64'h3F8,              64'h0,  64'h2A,                3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"popq",    4'hB, 64'h0,   64'h3F8,              64'h0,  64'h2A,                3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"rd1016",  4'h5, 64'd1016, 64'h0,               64'h0,  64'h2A,                3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"rd1017",  4'h5, 64'd1017, 64'h0,               64'h0,  64'h0,                 3'd3, 1'b1, 1});
    vecs.push_back('{"wr1017",  4'h4, 64'd1017, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0,                 3'd3, 1'b1, 1});
    vecs.push_back('{"rd1016b", 4'h5, 64'd1016, 64'h0,               64'h0,  64'h2A,                3'd1, 1'b0, MEMLAT});
    vecs.push_back('{"wrMax",   4'h4, 64'hFFFFFFFFFFFFFFFF, 64'h99,  64'h0,  64'h0,                 3'd3, 1'b1, 1});
    vecs.push_back('{"popBad",  4'hB, 64'h0,   64'd1024,             64'h0,  64'h0,                 3'd3, 1'b1, 1});
    vecs.push_back('{"nop6",    4'h6, 64'h10,  64'h77,               64'h0,  64'h0,                 3'd1, 1'b0, 1});
    vecs.push_back('{"halt0",   4'h0, 64'h10,  64'h0,                64'h0,  64'h0,                 3'd2, 1'b0, 1});
    vecs.push_back('{"insE",    4'hE, 64'h10,  64'h0,                64'h0,  64'h0,                 3'd4, 1'b0, 1});

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].ic, vecs[k].e, vecs[k].a, vecs[k].p, m, s, err, lat, da);
      modelOp(vecs[k].ic, vecs[k].e, vecs[k].a, vecs[k].p, xm, xs, xerr, xlat);
      checkOutput({vecs[k].name, " valM"}, m, vecs[k].m);
      checkOutput({vecs[k].name, " stat"}, 64'(s), 64'(vecs[k].s));
      checkOutput({vecs[k].name, " dmem_error"}, 64'(err), 64'(vecs[k].err));
      checkOutput({vecs[k].name, " latency"}, 64'(lat), 64'(vecs[k].lat));
      checkOutput({vecs[k].name, " done width"}, 64'(da), 64'h0);
    end

    // A second start while busy is ignored: exactly one done, carrying the
    // first request's results.
    bus.start = 1'b1;
    bus.icode = 4'h4;
    bus.valE  = 64'h40;
    bus.valA  = 64'h0123456789ABCDEF;
    @(negedge clk);
    bus.start = 1'b0;
    dc = 0;
    doneValM = 64'hDEAD;
    doneStat = 3'd0;
    for (int c = 1; c <= 16; c++) begin
      if (c == PULSE_AT) begin
        bus.start = 1'b1;
        bus.icode = 4'h5;
        bus.valE  = 64'h10;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dc++;
        doneValM = bus.valM;
        doneStat = bus.stat;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    modelOp(4'h4, 64'h40, 64'h0123456789ABCDEF, 64'h0, xm, xs, xerr, xlat);
    checkOutput("busy start done count", 64'(dc), 64'h1);
    checkOutput("busy start valM", doneValM, 64'h0);
    checkOutput("busy start stat", 64'(doneStat), 64'h1);
    runCheck("rd40", 4'h5, 64'h40, 64'h0, 64'h0);

    // Reset in the middle of a write keeps only the bytes already stored.
    bus.start = 1'b1;
    bus.icode = 4'h4;
    bus.valE  = 64'h20;
    bus.valA  = 64'hAAAAAAAAAAAAAAAA;
    for (int c = 1; c <= RST_AT; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst busy", 64'(bus.busy), 64'h0);
    checkOutput("midrst done", 64'(bus.done), 64'h0);
    checkOutput("midrst valM", bus.valM, 64'h0);
    checkOutput("midrst stat", 64'(bus.stat), 64'h1);
    checkOutput("midrst dmem_error", 64'(bus.dmem_error), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < RST_AT - 1; i++) mdl[32 + i] = 8'hAA;
    applyStimulus(4'h5, 64'h20, 64'h0, 64'h0, m, s, err, lat, da);
    modelOp(4'h5, 64'h20, 64'h0, 64'h0, xm, xs, xerr, xlat);
    checkOutput("midrst read valM", m, RST_READ);
    checkOutput("midrst read stat", 64'(s), 64'h1);

    // start together with reset: the request is dropped.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.icode = 4'h4;
    bus.valE  = 64'h30;
    bus.valA  = 64'h5A5A5A5A5A5A5A5A;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    dc = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done || bus.busy) dc++;
      @(negedge clk);
    end
    checkOutput("start+reset activity", 64'(dc), 64'h0);
    runCheck("rd30", 4'h5, 64'h30, 64'h0, 64'h0);

    // Randomized requests against the reference model.
    for (int n = 0; n < 80; n++) begin
      logic [3:0]  ic;
      logic [63:0] addr, e, a, p;
      int          sel;
      ic  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = 64'($urandom_range(0, DEPTH - 8));
      else if (sel == 7) addr = 64'(DEPTH - 8 + $urandom_range(1, 20));
      else if (sel == 8) addr = {$urandom, $urandom};
      else               addr = 64'(DEPTH - 8);
      if (ic == 4'h9 || ic == 4'hB) begin
        e = {$urandom, $urandom};
        a = addr;
      end else begin
        e = addr;
        a = {$urandom, $urandom};
      end
      p = {$urandom, $urandom};
      runCheck($sformatf("rand%0d ic%0h", n, ic), ic, e, a, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the SEQ Y86-64 datapath, directly upstream of writeback. It computes the data-memory address from execute/fetch results, performs the 8-byte little-endian read or write against an internal byte-addressed data memory, and produces `valM` and the instruction status. Writeback consumes the `valM` it produces. Accesses are byte-serial by default, with a start/busy/done handshake so the sequencer can stall until `valM` is valid.

## Interface
Parameters:
- `DEPTH`, default 1024: data memory size in bytes. Addresses `0..DEPTH-1` are valid.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `icode`  in  4  instruction code of the request.
- `valE`  in  64  ALU result, used as the address for rmmovq/mrmovq/pushq/call.
- `valA`  in  64  register operand: write data for rmmovq/pushq, address for popq/ret.
- `valP`  in  64  next PC: write data for call.
- `busy`  out  1  high while an access is in progress.
- `done`  out  1  one-cycle pulse; `valM`/`stat` valid from this cycle.
- `valM`  out  64  read data; 0 for non-read ops.
- `dmem_error`  out  1  address out of range on the last request.
- `stat`  out  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.

## Operation
- Ops by icode:
  - read @valE: 5 (mrmovq).
  - read @valA: 9 (ret), B (popq).
  - write valA @valE: 4 (rmmovq), A (pushq).
  - write valP @valE: 8 (call).
  - no access: 0, 1, 2, 3, 6, 7.
  - invalid: C–F, which give stat=INS with no access.
  - icode 0 gives stat=HLT, no access.
- Range check at sampling: an access is in range iff `addr <= DEPTH-8` (unsigned, 64-bit compare). Out of range gives stat=ADR and dmem_error=1; there is no memory access and no write.
- FSM states:
  - IDLE: on `start`, latch op, address and write data, clear the byte counter, and set valM=0. Go to ACCESS if this is an in-range memory op; otherwise go to DONE.
  - ACCESS: each cycle performs byte `cnt` at `addr+cnt`.
    - Writes store `data[8*cnt+7:8*cnt]`.
    - Reads place the byte into `valM[8*cnt+7:8*cnt]`.
    - At `cnt==7`, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- `busy` = state != IDLE.
- `valM`, `stat` and `dmem_error` hold their values until the next accepted `start`.
- `start` while busy is ignored; it is not queued.
- Memory contents are not cleared by reset.

## Timing
- Reset values: busy=0, done=0, valM=0, dmem_error=0, stat=1 (AOK). State is IDLE and the counter is 0.
- Let T be the edge that samples `start`.
  - No-access, HLT, INS or ADR: done is high in the cycle after T.
  - Memory op: bytes are accessed at edges T+1..T+8, and done is high in the cycle after T+8. Latency is 9 cycles start-to-done.
- The next `start` is accepted at the edge after done, or later.
- Reset mid-ACCESS: FSM returns to IDLE and outputs take their reset values. Bytes already written stay written.
- `start` and `reset` asserted together: reset wins and the request is dropped.

## Configuration
- `MEM_FAST_EN` defined: ACCESS performs all 8 bytes in one cycle. Done is high in the cycle after T+1 (latency 2). Range check, status codes and handshake are unchanged.
- `MEM_FAST_EN` undefined: byte-serial access as described above.

## Test plan
- Reset: hold reset 2 cycles, then check busy=0, done=0, valM=0, stat=1, dmem_error=0.
- Write then read:
  - rmmovq with valE=0x10, valA=0x1122334455667788 gives done after 9 cycles.
  - mrmovq with valE=0x10 then gives valM=0x1122334455667788.
  - mrmovq at valE=0x13 gives valM=0x0000001122334455, checking byte order.
- Stack pair:
  - call with valE=0x3F8, valP=0x2A, then ret with valA=0x3F8, gives valM=0x2A and stat=1.
  - popq with valA=0x3F8 gives the same valM.
- Boundary, with DEPTH=1024:
  - mrmovq valE=1016 is in range (stat=1).
  - valE=1017 gives stat=3, dmem_error=1, done after 1 cycle, and memory unchanged on re-read.
  - rmmovq with valE=0xFFFFFFFFFFFFFFFF gives stat=3.
- Non-memory and illegal codes:
  - icode 6 gives done after 1 cycle, valM=0, stat=1.
  - icode 0 gives stat=2.
  - icode 0xE gives stat=4.
  - start pulsed again at cycle 3 of a busy access is ignored, with exactly one done.
- Reset mid-write:
  - rmmovq valE=0x20, valA=0xAAAAAAAAAAAAAAAA over prior zeros; assert reset after 3 byte edges.
  - Then mrmovq valE=0x20 gives valM=0x0000000000AAAAAA.
  - With `MEM_FAST_EN`, repeat the write/read scenario and check done after 2 cycles.
